// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch slice: control state
// encodings, well-known instruction words and the address range check
// used by both the program-load and fetch paths.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_ERROR = 2'd3
  } ctrl_state_t;

  localparam logic [31:0] INST_NOP    = 32'h00000013;
  localparam logic [31:0] INST_EBREAK = 32'h00100073;
  localparam int unsigned INST_BYTES  = 4;

  // A word access is legal when word-aligned and its last byte lies inside
  // the memory. An aligned address cannot wrap when 3 is added.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] mem_bytes);
    return (addr[1:0] == 2'b00) && ((addr + 64'd3) < mem_bytes);
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of the load port, instruction memory port, fetch handshake and
// redirect signals around imem_fetch_ctrl. The master side is the fetch
// controller; the slave side is its environment (loader, memory, decode).
interface imem_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              load_done;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              fetch_valid;
  logic              fetch_ready;
  logic [ADDR_W-1:0] fetch_pc;
  logic [31:0]       fetch_inst;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output load_ready, mem_we, mem_addr, mem_wdata,
           fetch_valid, fetch_pc, fetch_inst,
    input  load_valid, load_addr, load_data, load_done,
           mem_rdata, fetch_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  load_ready, mem_we, mem_addr, mem_wdata,
           fetch_valid, fetch_pc, fetch_inst,
    output load_valid, load_addr, load_data, load_done,
           mem_rdata, fetch_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory port owner: routes the memory to the program loader
// while in LOAD, then sequences PC-driven fetches into a single registered
// valid/ready stage towards IF/ID, handling stalls, redirects, halt on
// ebreak and out-of-range fetches.
module imem_fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 64,
  parameter int unsigned       MEM_BYTES = 256,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       HALT_INST = INST_EBREAK
) (
  input  logic                clk,
  input  logic                reset_n,
  imem_fetch_ctrl_if.master   bus,
  output logic [1:0]          ctrl_state,
  output logic                err_oob
);

  ctrl_state_t       state;
  logic [ADDR_W-1:0] pc;
  logic              fetch_valid_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [31:0]       fetch_inst_q;
  logic              err_q;

  logic load_ok;
  logic pc_ok;
  logic advance;
  logic halt_accept;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return addr_in_range(64'(a), 64'(MEM_BYTES));
  endfunction

  // Hazard/handshake decode for the current cycle.
  always_comb begin
    load_ok     = in_range(bus.load_addr);
    pc_ok       = in_range(pc);
    advance     = !fetch_valid_q || bus.fetch_ready;
    halt_accept = fetch_valid_q && bus.fetch_ready && (fetch_inst_q == HALT_INST);
  end

  // Memory port mux: loader owns the port in LOAD, otherwise the PC drives
  // the read address (pc is frozen in HALT/ERROR so the address holds).
  always_comb begin
    bus.mem_we     = 1'b0;
    bus.mem_addr   = pc;
    bus.mem_wdata  = '0;
    bus.load_ready = 1'b0;
    if (state == ST_LOAD) begin
      bus.mem_we     = bus.load_valid && load_ok;
      bus.mem_addr   = bus.load_addr;
      bus.mem_wdata  = bus.load_data;
      bus.load_ready = 1'b1;
    end
  end

  // Control FSM with the IF/ID output register stage folded in.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_LOAD;
      pc            <= RESET_PC;
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= '0;
      fetch_inst_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      unique case (state)
        ST_LOAD: begin
          if (bus.load_valid && !load_ok) begin
            err_q <= 1'b1;
          end
          if (bus.load_done) begin
            state <= ST_RUN;
            pc    <= RESET_PC;
          end
        end
        ST_RUN: begin
          if (bus.redirect_valid) begin
            fetch_valid_q <= 1'b0;
            pc            <= bus.redirect_pc;
          end else if (halt_accept) begin
            // pc is left alone so mem_addr keeps its last value in HALT
            fetch_valid_q <= 1'b0;
            state         <= ST_HALT;
          end else if (advance) begin
            if (!pc_ok) begin
              err_q         <= 1'b1;
              fetch_valid_q <= 1'b0;
              state         <= ST_ERROR;
            end else begin
              fetch_inst_q  <= bus.mem_rdata;
              fetch_pc_q    <= pc;
              fetch_valid_q <= 1'b1;
              pc            <= pc + ADDR_W'(INST_BYTES);
            end
          end
        end
        default: begin
          fetch_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Registered outputs.
  always_comb begin
    bus.fetch_valid = fetch_valid_q;
    bus.fetch_pc    = fetch_pc_q;
    bus.fetch_inst  = fetch_inst_q;
    ctrl_state      = state;
    err_oob         = err_q;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Owns the instruction memory port and sequences it between two requesters: a program-load port (test bench / boot loader writing words) and the pipeline fetch path.
- Maintains the PC and presents one registered instruction per cycle to IF/ID over a valid/ready handshake.
- Handles stalls (load-use hazard) and redirects (taken branch / flush).
- Sits between Instruction_Memory (extended with a write port) and the IF/ID pipeline register.

Parameters:
ADDR_W, 64, PC / memory address width
MEM_BYTES, 256, instruction memory size in bytes; fetches at or beyond this are out of range
RESET_PC, 0, PC loaded on entry to RUN
HALT_INST, 32'h00100073, instruction (ebreak) that halts fetch once accepted by decode

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous active-low reset
load_valid  in  1  load port word valid
load_ready  out  1  load port may write (1 only in LOAD)
load_addr  in  ADDR_W  byte address of word to write
load_data  in  32  word to write
load_done  in  1  one-cycle pulse: program loaded, start fetching
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory byte address (write or read)
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, combinational from mem_addr
fetch_valid  out  1  fetch_inst/fetch_pc valid
fetch_ready  in  1  decode accepts; 0 = stall
fetch_pc  out  ADDR_W  PC of fetch_inst
fetch_inst  out  32  fetched instruction
redirect_valid  in  1  flush and redirect fetch
redirect_pc  in  ADDR_W  redirect target
ctrl_state  out  2  0=LOAD 1=RUN 2=HALT 3=ERROR
err_oob  out  1  sticky: misaligned or out-of-range fetch

Behaviour:
- Reset (reset_n=0 at clk edge):
  - State=LOAD; pc=RESET_PC.
  - fetch_valid=0, fetch_pc=0, fetch_inst=0, err_oob=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-write or mid-fetch abandons the operation; memory contents are not cleared.
- LOAD state:
  - load_ready=1.
  - Combinational port mapping: mem_we=load_valid, mem_addr=load_addr, mem_wdata=load_data. A write occurs on every cycle with load_valid=1.
  - Writes with load_addr[1:0]!=0 or load_addr+3>=MEM_BYTES are suppressed (mem_we=0) and set err_oob. State stays LOAD.
  - load_done=1 → RUN next cycle with pc=RESET_PC. If load_valid and load_done are both 1 in one cycle, that write still completes.
  - fetch_valid=0 throughout. redirect_valid is ignored.
- RUN state:
  - load_ready=0; load_valid is ignored; mem_we=0; mem_addr=pc.
  - advance = !fetch_valid || fetch_ready.
  - Priority 1, redirect_valid=1: fetch_valid←0 (flush), pc←redirect_pc. Overrides both stall and advance.
  - Priority 2, advance: fetch_inst←mem_rdata, fetch_pc←pc, fetch_valid←1, pc←pc+4 (mod 2^ADDR_W).
  - Priority 3, stall: all outputs and pc hold.
  - Latency: load_done at cycle N → first fetch_valid=1 at N+2. After a redirect at cycle M, the target instruction is valid at M+2 (one bubble).
  - Range check on an advance: if pc[1:0]!=0 or pc+3>=MEM_BYTES, set err_oob, keep fetch_valid=0, and go to ERROR.
  - HALT_INST accepted (fetch_valid && fetch_ready && fetch_inst==HALT_INST) → HALT next cycle, fetch_valid←0. A redirect in the same cycle takes precedence and the state stays RUN.
- HALT and ERROR states:
  - Terminal until reset.
  - fetch_valid=0, mem_we=0, load_ready=0.
  - mem_addr holds its last value.

Decomposition:
- Shared package riscv_pkg holds:
  - ctrl_state encodings: LOAD, RUN, HALT, ERROR.
  - INST_NOP=32'h00000013.
  - INST_EBREAK=32'h00100073.
  - INST_BYTES=4.
- No sub-module required. The single output register stage is inline.
- The range/alignment check (addr_in_range) is written as a function in riscv_pkg so the load and fetch paths share it.

Test Plan:
- Load words 0x10000293 @0, 0x00700313 @4, 0x00100073 @8, pulse load_done, fetch_ready=1 → fetch_pc 0,4,8 with matching insts starting 2 cycles after load_done; HALT entered after the ebreak is accepted.
- RUN with fetch_ready=0 for 3 cycles while fetch_pc=4 → fetch_pc/fetch_inst hold 4/0x00700313, pc unchanged; resumes with 8 the cycle after ready returns.
- redirect_valid=1 with redirect_pc=0x20 while fetch_ready=0 → fetch_valid=0 next cycle, then fetch_pc=0x20 valid one cycle later.
- Load write to address 0x102 or 0x100 (MEM_BYTES=256) → mem_we=0, err_oob=1, state stays LOAD.
- Redirect to 0x100 → ctrl_state=ERROR, err_oob=1, fetch_valid stays 0; reset_n=0 for one edge → LOAD, err_oob=0.
- load_valid=1 during RUN → mem_we never 1, load_ready=0, memory contents unchanged on readback.
